// File: rtl/snake_game_seq.sv
// Per-tick snake sequencer: owns the body ring buffer, steps the head, scans the body
// for self-collision and emits pixel set/clear and food-request strobes.
module snake_game_seq #(
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned GRID_W    = 16,
  parameter int unsigned GRID_H    = 8,
  parameter int unsigned START_X   = 4,
  parameter int unsigned START_Y   = 3,
  parameter int unsigned START_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       tick,
  input  logic [1:0] dir,
  input  logic [7:0] foodPos,
  output logic [7:0] headPos,
  output logic [7:0] tailPos,
  output logic [5:0] len,
  output logic       pixSet,
  output logic       pixClr,
  output logic [7:0] pixPos,
  output logic       foodReq,
  output logic       busy,
  output logic       gameOver
);

  localparam int unsigned AW = $clog2(MAX_LEN);

  typedef enum logic [2:0] {StInit, StWait, StCalc, StScan, StCommit, StOver} state_e;

  state_e          r_state, w_state_next;
  logic [1:0]      r_dir;
  logic [AW-1:0]   r_head_ptr, r_tail_ptr, r_scan_idx, r_clr_idx;
  logic [5:0]      r_len, r_scan_left, r_clr_left, r_cnt;
  logic [7:0]      r_head_pos, r_tail_pos, r_next_head, r_clr_pos;
  logic            r_grow, r_food_hit, r_clr_pend;
  logic [7:0]      r_buf [MAX_LEN];

  logic [AW-1:0]   w_head_nxt, w_tail_nxt;
  logic [3:0]      w_hx, w_hy, w_init_x;
  logic [7:0]      w_init_pos, w_nh;
  logic            w_wall, w_grow, w_opp, w_scan_hit, w_clearing;
  logic [1:0]      w_eff_dir;

  assign w_head_nxt = r_head_ptr + AW'(1);
  assign w_tail_nxt = r_tail_ptr + AW'(1);
  assign w_hx       = r_head_pos[7:4];
  assign w_hy       = r_head_pos[3:0];
  assign w_init_x   = 4'(START_X + 1 - START_LEN) + r_cnt[3:0];
  assign w_init_pos = {w_init_x, 4'(START_Y)};
  // Up/down and left/right differ only in bit 0, so same bit 1 means opposite.
  assign w_opp      = (dir[1] == r_dir[1]) && (dir[0] != r_dir[0]);
  assign w_eff_dir  = w_opp ? r_dir : dir;
  assign w_grow     = (w_nh == foodPos) && (r_len < 6'(MAX_LEN));
  assign w_scan_hit = (r_buf[r_scan_idx] == r_next_head);
  // After a restart the old body is erased before the new one is drawn.
  assign w_clearing = (r_clr_left != 6'd0);

  always_comb begin
    w_nh   = r_head_pos;
    w_wall = 1'b0;
    unique case (r_dir)
      2'b00: begin w_wall = (w_hy == 4'd0);              w_nh = {w_hx, w_hy - 4'd1}; end
      2'b01: begin w_wall = (w_hy == 4'(GRID_H - 1));    w_nh = {w_hx, w_hy + 4'd1}; end
      2'b10: begin w_wall = (w_hx == 4'd0);              w_nh = {w_hx - 4'd1, w_hy}; end
      2'b11: begin w_wall = (w_hx == 4'(GRID_W - 1));    w_nh = {w_hx + 4'd1, w_hy}; end
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StInit:   if (!w_clearing && r_cnt == 6'(START_LEN - 1)) w_state_next = StWait;
      StWait:   if (tick) w_state_next = StCalc;
      StCalc:   w_state_next = w_wall ? StOver : StScan;
      StScan:   if (w_scan_hit) w_state_next = StOver;
                else if (r_scan_left == 6'd1) w_state_next = StCommit;
      StCommit: w_state_next = StWait;
      StOver:   if (init) w_state_next = StInit;
      default:  w_state_next = StInit;
    endcase
  end

  always_comb begin
    pixSet  = ~reset & (((r_state == StInit) && !w_clearing) || (r_state == StCommit));
    pixClr  = ~reset & (((r_state == StInit) && w_clearing) ||
                        ((r_state == StWait) && r_clr_pend));
    foodReq = ~reset & (r_state == StCommit) & r_food_hit;
    pixPos  = r_clr_pos;
    if (r_state == StInit)        pixPos = w_clearing ? r_buf[r_clr_idx] : w_init_pos;
    else if (r_state == StCommit) pixPos = r_next_head;
  end

  assign busy     = (r_state != StWait) && (r_state != StOver);
  assign gameOver = (r_state == StOver);
  assign headPos  = r_head_pos;
  assign tailPos  = r_tail_pos;
  assign len      = r_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StInit;
      r_dir       <= 2'b11;
      r_head_ptr  <= '0;
      r_tail_ptr  <= '0;
      r_scan_idx  <= '0;
      r_clr_idx   <= '0;
      r_len       <= '0;
      r_scan_left <= '0;
      r_clr_left  <= '0;
      r_cnt       <= '0;
      r_head_pos  <= {4'(START_X), 4'(START_Y)};
      r_tail_pos  <= {4'(START_X), 4'(START_Y)};
      r_next_head <= '0;
      r_clr_pos   <= '0;
      r_grow      <= 1'b0;
      r_food_hit  <= 1'b0;
      r_clr_pend  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_clr_pend <= 1'b0;
      unique case (r_state)
        StInit: begin
          if (w_clearing) begin
            r_clr_idx  <= r_clr_idx + AW'(1);
            r_clr_left <= r_clr_left - 6'd1;
          end else begin
            r_head_ptr <= r_cnt[AW-1:0];
            r_head_pos <= w_init_pos;
            if (r_cnt == 6'd0) r_tail_pos <= w_init_pos;
            if (r_cnt == 6'(START_LEN - 1)) begin
              r_len <= 6'(START_LEN);
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        StWait: if (tick) r_dir <= w_eff_dir;
        StCalc: begin
          r_next_head <= w_nh;
          r_grow      <= w_grow;
          r_food_hit  <= (w_nh == foodPos);
          // The tail vacates this step unless growing, so it cannot be hit.
          r_scan_idx  <= w_grow ? r_tail_ptr : w_tail_nxt;
          r_scan_left <= w_grow ? r_len : r_len - 6'd1;
        end
        StScan: begin
          r_scan_idx  <= r_scan_idx + AW'(1);
          r_scan_left <= r_scan_left - 6'd1;
        end
        StCommit: begin
          r_head_ptr <= w_head_nxt;
          r_head_pos <= r_next_head;
          if (r_grow) begin
            r_len <= r_len + 6'd1;
          end else begin
            r_tail_ptr <= w_tail_nxt;
            r_tail_pos <= r_buf[w_tail_nxt];
            r_clr_pend <= 1'b1;
            r_clr_pos  <= r_tail_pos;
          end
        end
        StOver: begin
          if (init) begin
            r_clr_idx  <= r_tail_ptr;
            r_clr_left <= r_len;
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_dir      <= 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == StInit && !w_clearing) r_buf[r_cnt[AW-1:0]] <= w_init_pos;
    if (r_state == StCommit)              r_buf[w_head_nxt]    <= r_next_head;
  end

endmodule

// File: tb/tb_snake_game_seq.sv
// Randomised bench for snake_game_seq: a queue-based game model predicts every cycle's
// outputs and a negedge process compares them against the DUT.
module tb_snake_game_seq;
  localparam int MAX_LEN = 32, GW = 16, GH = 8, SX = 4, SY = 3, SL = 3;

  logic       clk = 1'b0, reset = 1'b1, init = 1'b0, tick = 1'b0;
  logic [1:0] dir = 2'b00;
  logic [7:0] foodPos = 8'h00;
  logic [7:0] headPos, tailPos, pixPos;
  logic [5:0] len;
  logic       pixSet, pixClr, foodReq, busy, gameOver;

  snake_game_seq #(
    .MAX_LEN(MAX_LEN), .GRID_W(GW), .GRID_H(GH),
    .START_X(SX), .START_Y(SY), .START_LEN(SL)
  ) dut (
    .clk(clk), .reset(reset), .init(init), .tick(tick), .dir(dir), .foodPos(foodPos),
    .headPos(headPos), .tailPos(tailPos), .len(len), .pixSet(pixSet), .pixClr(pixClr),
    .pixPos(pixPos), .foodReq(foodReq), .busy(busy), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  logic       chk_en = 1'b0;
  logic       e_set, e_clr, e_freq, e_busy, e_over;
  logic [7:0] e_pos, e_head, e_tail;
  logic [5:0] e_len;

  // Game model: body[0] is the tail, body[$] the head.
  logic [7:0] body[$];
  logic [7:0] m_head, m_tail, m_pend_pos;
  int         m_len;
  logic [1:0] cur_dir;
  bit         m_over, m_pend;

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("pixSet", pixSet, e_set);
      cmp("pixClr", pixClr, e_clr);
      cmp("foodReq", foodReq, e_freq);
      cmp("busy", busy, e_busy);
      cmp("gameOver", gameOver, e_over);
      cmp("headPos", headPos, e_head);
      cmp("tailPos", tailPos, e_tail);
      cmp("len", len, e_len);
      if (e_set || e_clr) cmp("pixPos", pixPos, e_pos);
    end
  end

  // Publish the expectation for the current cycle, then move to the next one.
  task automatic emit(input bit s, input bit c, input logic [7:0] p, input bit fr,
                      input bit b, input bit o);
    e_set = s; e_clr = c; e_pos = p; e_freq = fr; e_busy = b; e_over = o;
    e_head = m_head; e_tail = m_tail; e_len = 6'(m_len);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic bit next_pos(input logic [7:0] p, input logic [1:0] d,
                                  output logic [7:0] np);
    int x = int'(p[7:4]);
    int y = int'(p[3:0]);
    case (d)
      2'd0:    y = y - 1;
      2'd1:    y = y + 1;
      2'd2:    x = x - 1;
      default: x = x + 1;
    endcase
    np = {x[3:0], y[3:0]};
    return (x >= 0 && x < GW && y >= 0 && y < GH);
  endfunction

  function automatic logic [1:0] eff_dir(input logic [1:0] req, input logic [1:0] cur);
    bit opp = (req == 0 && cur == 1) || (req == 1 && cur == 0) ||
              (req == 2 && cur == 3) || (req == 3 && cur == 2);
    return opp ? cur : req;
  endfunction

  function automatic logic [1:0] serp(input logic [7:0] p);
    if (p[0]) return (p[7:4] == 4'd15) ? 2'd1 : 2'd3;
    else      return (p[7:4] == 4'd0)  ? 2'd1 : 2'd2;
  endfunction

  task automatic idle_wait(input int n);
    tick = 1'b0;
    repeat (n) begin
      emit(0, m_pend, m_pend_pos, 0, 0, 0);
      m_pend = 0;
    end
  endtask

  task automatic idle_over(input int n);
    repeat (n) begin
      tick = 1'($urandom % 2);
      dir  = 2'($urandom % 4);
      emit(0, 0, 8'h00, 0, 0, 1);
    end
    tick = 1'b0;
  endtask

  task automatic init_writes();
    logic [7:0] p;
    for (int i = 0; i < SL; i++) begin
      p = {4'(SX - SL + 1 + i), 4'(SY)};
      emit(1, 0, p, 0, 1, 0);
      if (i == 0) m_tail = p;
      m_head = p;
      body.push_back(p);
    end
    m_len = SL;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; tick = 1'b0; init = 1'b0;
    body.delete();
    m_head = {4'(SX), 4'(SY)}; m_tail = m_head; m_len = 0;
    cur_dir = 2'd3; m_over = 0; m_pend = 0;
    repeat (n) emit(0, 0, 8'h00, 0, 1, 0);
    reset = 1'b0;
    init_writes();
  endtask

  task automatic restart();
    init = 1'b1;
    emit(0, 0, 8'h00, 0, 0, 1);
    init = 1'b0;
    m_len = 0; cur_dir = 2'd3; m_over = 0;
    foreach (body[i]) emit(0, 1, body[i], 0, 1, 0);
    body.delete();
    init_writes();
  endtask

  task automatic busy_noise();
    tick = 1'($urandom % 2);
    dir  = 2'($urandom % 4);
  endtask

  task automatic game_step(input logic [1:0] d, input logic [7:0] food);
    logic [7:0] nh;
    bit ok, grow, hit_food;
    tick = 1'b1; dir = d; foodPos = food;
    emit(0, m_pend, m_pend_pos, 0, 0, 0);
    m_pend = 0;
    cur_dir = eff_dir(d, cur_dir);
    busy_noise();
    ok = next_pos(m_head, cur_dir, nh);
    emit(0, 0, 8'h00, 0, 1, 0);
    if (!ok) begin
      m_over = 1; tick = 1'b0;
      return;
    end
    hit_food = (nh == food);
    grow = hit_food && (m_len < MAX_LEN);
    for (int k = (grow ? 0 : 1); k < body.size(); k++) begin
      busy_noise();
      emit(0, 0, 8'h00, 0, 1, 0);
      if (body[k] == nh) begin
        m_over = 1; tick = 1'b0;
        return;
      end
    end
    busy_noise();
    emit(1, 0, nh, hit_food, 1, 0);
    tick = 1'b0;
    body.push_back(nh);
    m_head = nh;
    if (grow) m_len++;
    else begin
      m_pend_pos = body.pop_front();
      m_pend = 1;
      m_tail = body[0];
    end
  endtask

  initial begin
    logic [1:0] d, ed;
    logic [7:0] np, food;
    bit okp;

    do_reset(3);
    idle_wait(2);
    cmp("pin init head", headPos, 8'h43);
    cmp("pin init tail", tailPos, 8'h23);
    cmp("pin init len", len, 3);

    game_step(2'd3, 8'h00);
    idle_wait(1);
    cmp("pin move head", headPos, 8'h53);
    cmp("pin move tail", tailPos, 8'h33);
    cmp("pin move len", len, 3);

    game_step(2'd3, 8'h63);
    cmp("pin grow len", len, 4);
    cmp("pin grow head", headPos, 8'h63);

    game_step(2'd2, 8'h00);
    cmp("pin reverse head", headPos, 8'h73);

    for (int i = 0; i < 12 && !m_over; i++) game_step(2'd3, 8'h00);
    cmp("pin wall over", gameOver, 1);
    idle_over(3);
    restart();
    idle_wait(1);

    game_step(2'd3, 8'h53);
    game_step(2'd3, 8'h63);
    cmp("pin len5", len, 5);
    game_step(2'd0, 8'h00);
    game_step(2'd2, 8'h00);
    game_step(2'd1, 8'h00);
    cmp("pin self hit over", gameOver, 1);
    idle_over(3);
    cmp("pin tick in over", gameOver, 1);
    restart();
    idle_wait(2);

    // Abort a step with reset while the sequencer is busy.
    tick = 1'b1; dir = 2'd3; foodPos = 8'h00;
    emit(0, m_pend, m_pend_pos, 0, 0, 0);
    m_pend = 0; tick = 1'b0;
    emit(0, 0, 8'h00, 0, 1, 0);
    do_reset(2);
    idle_wait(1);

    // Serpentine with food always ahead, growing to the length cap and beyond.
    for (int i = 0; i < 40 && !m_over; i++) begin
      d = serp(m_head);
      okp = next_pos(m_head, d, np);
      game_step(d, np);
    end
    idle_wait(1);
    cmp("pin max len", len, MAX_LEN);
    do_reset(2);
    idle_wait(1);

    for (int s = 0; s < 300; s++) begin
      if (m_over) begin
        idle_over($urandom_range(1, 3));
        restart();
        idle_wait($urandom_range(0, 2));
      end else begin
        d = 2'($urandom % 4);
        ed = eff_dir(d, cur_dir);
        okp = next_pos(m_head, ed, np);
        if (($urandom % 3) == 0 || !okp) food = {4'($urandom % 16), 4'($urandom % 8)};
        else food = np;
        game_step(d, food);
        if (!m_over) idle_wait($urandom_range(0, 2));
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
